// File: rtl/ticket_buyer_if.sv
// Ticket buyer port bundle: request handshake, vendor drive/return lines and the result.
// slave = buyer side, master = requester/vendor side.
interface ticket_buyer_if #(
  parameter int ST_W  = 8,
  parameter int CNT_W = 8,
  parameter int TEN_W = 4,
  parameter int CHG_W = 8
);
  logic             req_valid;
  logic             req_ready;
  logic [ST_W-1:0]  req_src;
  logic [ST_W-1:0]  req_dest;
  logic [CNT_W-1:0] req_count;
  logic [TEN_W-1:0] req_tens;

  logic [ST_W-1:0]  src;
  logic [ST_W-1:0]  dest;
  logic [CNT_W-1:0] count;
  logic             ten_insert;
  logic             done;
  logic             ticket;
  logic             one_output;

  logic             rsp_valid;
  logic [CNT_W-1:0] rsp_tickets;
  logic [CHG_W-1:0] rsp_change;
  logic             rsp_ok;

  modport slave (
    input  req_valid, req_src, req_dest, req_count, req_tens, ticket, one_output,
    output req_ready, src, dest, count, ten_insert, done,
           rsp_valid, rsp_tickets, rsp_change, rsp_ok
  );

  modport master (
    output req_valid, req_src, req_dest, req_count, req_tens, ticket, one_output,
    input  req_ready, src, dest, count, ten_insert, done,
           rsp_valid, rsp_tickets, rsp_change, rsp_ok
  );
endinterface

// File: rtl/ticket_buyer.sv
// Customer-side initiator for the ticket vendor: plays one purchase onto the vendor
// inputs, then counts returned ticket/change pulses until the line goes quiet.
module ticket_buyer #(
  parameter int ST_W     = 8,
  parameter int CNT_W    = 8,
  parameter int TEN_W    = 4,
  parameter int CHG_W    = 8,
  parameter int DONE_CYC = 2,
  parameter int IDLE_TO  = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  ticket_buyer_if.slave  bus
);

  localparam int QW = $clog2(IDLE_TO + 1);
  localparam int DW = $clog2(DONE_CYC + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_INS_HI, S_INS_LO, S_DONE, S_COLLECT, S_RESP
  } state_e;

  state_e           state_q;
  logic             req_ready_q;
  logic [ST_W-1:0]  src_q, dest_q;
  logic [CNT_W-1:0] count_q;
  logic [TEN_W-1:0] tens_q;
  logic             ten_insert_q, done_q;
  logic [DW-1:0]    done_cnt_q;
  logic [QW-1:0]    quiet_q;
  logic             tick_prev_q, one_prev_q;
  logic [CNT_W-1:0] tick_cnt_q, tick_cnt_d;
  logic [CHG_W-1:0] chg_cnt_q, chg_cnt_d;
  logic             rsp_valid_q, rsp_ok_q;
  logic [CNT_W-1:0] rsp_tickets_q;
  logic [CHG_W-1:0] rsp_change_q;

  logic tick_edge, one_edge;
  assign tick_edge = bus.ticket & ~tick_prev_q;
  assign one_edge  = bus.one_output & ~one_prev_q;

  // Saturating pulse counters, live in every non-idle state.
  always_comb begin
    tick_cnt_d = tick_cnt_q;
    chg_cnt_d  = chg_cnt_q;
    if (state_q != S_IDLE) begin
      if (tick_edge && (tick_cnt_q != '1)) tick_cnt_d = tick_cnt_q + 1'b1;
      if (one_edge  && (chg_cnt_q  != '1)) chg_cnt_d  = chg_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      req_ready_q   <= 1'b1;
      src_q         <= '0;
      dest_q        <= '0;
      count_q       <= '0;
      tens_q        <= '0;
      ten_insert_q  <= 1'b0;
      done_q        <= 1'b0;
      done_cnt_q    <= '0;
      quiet_q       <= '0;
      tick_prev_q   <= 1'b0;
      one_prev_q    <= 1'b0;
      tick_cnt_q    <= '0;
      chg_cnt_q     <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_tickets_q <= '0;
      rsp_change_q  <= '0;
      rsp_ok_q      <= 1'b0;
    end else begin
      tick_prev_q <= bus.ticket;
      one_prev_q  <= bus.one_output;
      tick_cnt_q  <= tick_cnt_d;
      chg_cnt_q   <= chg_cnt_d;
      rsp_valid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (bus.req_valid && req_ready_q) begin
            src_q       <= bus.req_src;
            dest_q      <= bus.req_dest;
            count_q     <= bus.req_count;
            tens_q      <= bus.req_tens;
            tick_cnt_q  <= '0;
            chg_cnt_q   <= '0;
            req_ready_q <= 1'b0;
            state_q     <= S_LOAD;
          end
        end
        S_LOAD: begin
          if (tens_q != '0) begin
            ten_insert_q <= 1'b1;
            state_q      <= S_INS_HI;
          end else begin
            done_q     <= 1'b1;
            done_cnt_q <= '0;
            state_q    <= S_DONE;
          end
        end
        S_INS_HI: begin
          ten_insert_q <= 1'b0;
          state_q      <= S_INS_LO;
        end
        S_INS_LO: begin
          tens_q <= tens_q - 1'b1;
          if (tens_q != TEN_W'(1)) begin
            ten_insert_q <= 1'b1;
            state_q      <= S_INS_HI;
          end else begin
            done_q     <= 1'b1;
            done_cnt_q <= '0;
            state_q    <= S_DONE;
          end
        end
        S_DONE: begin
          if (done_cnt_q == DW'(DONE_CYC - 1)) begin
            done_q  <= 1'b0;
            quiet_q <= '0;
            state_q <= S_COLLECT;
          end else begin
            done_cnt_q <= done_cnt_q + 1'b1;
          end
        end
        S_COLLECT: begin
          // Leaving one count early lands RESP exactly IDLE_TO quiet cycles in.
          if (tick_edge || one_edge) begin
            quiet_q <= '0;
          end else if (quiet_q == QW'(IDLE_TO - 1)) begin
            rsp_valid_q   <= 1'b1;
            rsp_tickets_q <= tick_cnt_q;
            rsp_change_q  <= chg_cnt_q;
            rsp_ok_q      <= (tick_cnt_q == count_q);
            state_q       <= S_RESP;
          end else begin
            quiet_q <= quiet_q + 1'b1;
          end
        end
        S_RESP: begin
          src_q       <= '0;
          dest_q      <= '0;
          count_q     <= '0;
          req_ready_q <= 1'b1;
          state_q     <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.req_ready   = req_ready_q;
  assign bus.src         = src_q;
  assign bus.dest        = dest_q;
  assign bus.count       = count_q;
  assign bus.ten_insert  = ten_insert_q;
  assign bus.done        = done_q;
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_tickets = rsp_tickets_q;
  assign bus.rsp_change  = rsp_change_q;
  assign bus.rsp_ok      = rsp_ok_q;

endmodule

// File: tb/tb_ticket_buyer.sv
// Self-checking bench for ticket_buyer: vector table plus scoreboard of responses,
// with hand sequences for reset abort and a request held while busy.
module tb_ticket_buyer;

  localparam int DONE_CYC = 2;
  localparam int IDLE_TO  = 16;

  logic clk;
  logic rst_n;

  ticket_buyer_if #(.ST_W(8), .CNT_W(8), .TEN_W(4), .CHG_W(8)) bus ();

  ticket_buyer #(
    .ST_W(8), .CNT_W(8), .TEN_W(4), .CHG_W(8),
    .DONE_CYC(DONE_CYC), .IDLE_TO(IDLE_TO)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] src;
    logic [7:0] dest;
    logic [7:0] count;
    logic [3:0] tens;
    int         nt;
    int         nc;
    int         hold;
    logic [7:0] xt;
    logic [7:0] xc;
    logic       xok;
  } vec_t;

  typedef struct {
    logic [7:0] t;
    logic [7:0] c;
    logic       ok;
  } rsp_exp_t;

  rsp_exp_t sb[$];
  vec_t     vecs[6];
  int       nchecks = 0;
  int       nerrors = 0;
  int       tcnt    = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchecks++;
    if (act !== exp) begin
      nerrors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    tcnt++;
  endtask

  // Response scoreboard
  always @(negedge clk) begin
    if (rst_n && bus.rsp_valid) begin
      if (sb.size() == 0) begin
        chk("unexpected_rsp", 32'd1, 32'd0);
      end else begin
        rsp_exp_t e;
        e = sb.pop_front();
        chk("rsp_tickets", 32'(bus.rsp_tickets), 32'(e.t));
        chk("rsp_change",  32'(bus.rsp_change),  32'(e.c));
        chk("rsp_ok",      32'(bus.rsp_ok),      32'(e.ok));
      end
    end
  end

  task automatic wait_ready(input string tag);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (bus.req_ready) begin
        ok = 1'b1;
        break;
      end
    end
    chk({tag, "_ready"}, 32'(ok), 32'd1);
  endtask

  task automatic wait_rsp(input string tag, output int at);
    bit ok;
    ok = 1'b0;
    at = 0;
    for (int i = 0; i < IDLE_TO + 40; i++) begin
      tick();
      if (bus.rsp_valid) begin
        ok = 1'b1;
        at = tcnt;
        break;
      end
    end
    chk({tag, "_rsp_seen"}, 32'(ok), 32'd1);
  endtask

  task automatic drive_req(input vec_t v);
    bus.req_src   = v.src;
    bus.req_dest  = v.dest;
    bus.req_count = v.count;
    bus.req_tens  = v.tens;
    bus.req_valid = 1'b1;
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int  ten_seen, dcyc, dcnt, t_done, t_rsp, np;
    bit  got_done;
    wait_ready(tag);
    sb.push_back('{v.xt, v.xc, v.xok});
    drive_req(v);
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    tick();
    chk({tag, "_load_src"},   32'(bus.src),   32'(v.src));
    chk({tag, "_load_dest"},  32'(bus.dest),  32'(v.dest));
    chk({tag, "_load_count"}, 32'(bus.count), 32'(v.count));
    chk({tag, "_load_ten"},   32'(bus.ten_insert), 32'd0);
    chk({tag, "_busy"},       32'(bus.req_ready),  32'd0);
    ten_seen = 0;
    got_done = 1'b0;
    dcyc = 0;
    for (int c = 2; c < 2 + 2 * 16 + 4; c++) begin
      tick();
      if (bus.done) begin
        got_done = 1'b1;
        dcyc = c;
        break;
      end
      if (bus.ten_insert) begin
        if (ten_seen == 0) chk({tag, "_first_ten_cyc"}, 32'(c), 32'd2);
        ten_seen++;
      end
    end
    chk({tag, "_done_seen"}, 32'(got_done), 32'd1);
    chk({tag, "_done_cyc"},  32'(dcyc), 32'(2 + 2 * int'(v.tens)));
    chk({tag, "_ten_pulses"}, 32'(ten_seen), 32'(v.tens));
    t_done = tcnt;
    dcnt = 1;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (!bus.done) break;
      dcnt++;
    end
    chk({tag, "_done_len"}, 32'(dcnt), 32'(DONE_CYC));
    np = (v.nt > v.nc) ? v.nt : v.nc;
    for (int i = 0; i < np; i++) begin
      bus.ticket     = (i < v.nt);
      bus.one_output = (i < v.nc);
      repeat (v.hold) tick();
      bus.ticket     = 1'b0;
      bus.one_output = 1'b0;
      tick();
    end
    wait_rsp(tag, t_rsp);
    chk({tag, "_rsp_lat"}, 32'((t_rsp - t_done) >= DONE_CYC + IDLE_TO), 32'd1);
    tick();
    chk({tag, "_rsp_pulse"},  32'(bus.rsp_valid),   32'd0);
    chk({tag, "_idle_ready"}, 32'(bus.req_ready),   32'd1);
    chk({tag, "_idle_src"},   32'(bus.src),         32'd0);
    chk({tag, "_rsp_stable"}, 32'(bus.rsp_tickets), 32'(v.xt));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors + 1);
    $fatal(1, "timeout");
  end

  initial begin
    vec_t a, b, ab;
    int   bad, t_rsp;
    bit   ok;

    //            src    dest   cnt    tens  nt   nc  hold  xt     xc    xok
    vecs[0] = '{8'h87, 8'h81, 8'd3,   4'd1, 3,   1,  1, 8'd3,   8'd1, 1'b1};
    vecs[1] = '{8'h02, 8'hD1, 8'd5,   4'd2, 5,   0,  1, 8'd5,   8'd0, 1'b1};
    vecs[2] = '{8'h05, 8'h8B, 8'd3,   4'd2, 3,   5,  1, 8'd3,   8'd5, 1'b1};
    vecs[3] = '{8'h05, 8'h8B, 8'd3,   4'd1, 0,   0,  1, 8'd0,   8'd0, 1'b0};
    vecs[4] = '{8'h10, 8'h20, 8'd2,   4'd0, 1,   0,  3, 8'd1,   8'd0, 1'b0};
    vecs[5] = '{8'h11, 8'h22, 8'd255, 4'd0, 300, 0,  1, 8'd255, 8'd0, 1'b1};

    bus.req_valid  = 1'b0;
    bus.req_src    = '0;
    bus.req_dest   = '0;
    bus.req_count  = '0;
    bus.req_tens   = '0;
    bus.ticket     = 1'b0;
    bus.one_output = 1'b0;
    rst_n = 1'b0;

    repeat (2) tick();
    chk("rst_ready", 32'(bus.req_ready),  32'd1);
    chk("rst_src",   32'(bus.src),        32'd0);
    chk("rst_dest",  32'(bus.dest),       32'd0);
    chk("rst_count", 32'(bus.count),      32'd0);
    chk("rst_ten",   32'(bus.ten_insert), 32'd0);
    chk("rst_done",  32'(bus.done),       32'd0);
    chk("rst_rspv",  32'(bus.rsp_valid),  32'd0);
    chk("rst_rspt",  32'(bus.rsp_tickets), 32'd0);
    chk("rst_rspok", 32'(bus.rsp_ok),     32'd0);
    rst_n = 1'b1;
    repeat (3) tick();
    chk("rel_ready", 32'(bus.req_ready), 32'd1);
    chk("rel_done",  32'(bus.done),      32'd0);
    chk("rel_rspv",  32'(bus.rsp_valid), 32'd0);

    for (int i = 0; i < 6; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Reset landing in INS_LO discards the transaction.
    ab = '{8'h66, 8'h77, 8'd4, 4'd3, 0, 0, 1, 8'd0, 8'd0, 1'b0};
    wait_ready("abort");
    drive_req(ab);
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    tick();
    tick();
    chk("abort_ins_hi", 32'(bus.ten_insert), 32'd1);
    tick();
    chk("abort_ins_lo", 32'(bus.ten_insert), 32'd0);
    rst_n = 1'b0;
    #1;
    chk("abort_src",   32'(bus.src),       32'd0);
    chk("abort_count", 32'(bus.count),     32'd0);
    chk("abort_ten",   32'(bus.ten_insert), 32'd0);
    chk("abort_done",  32'(bus.done),      32'd0);
    chk("abort_ready", 32'(bus.req_ready), 32'd1);
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (IDLE_TO + 12) tick();
    chk("abort_no_rsp", 32'(sb.size()), 32'd0);
    run_vec(vecs[0], "post_abort");

    // Request held while busy must wait for the next IDLE.
    a = '{8'h31, 8'h32, 8'd0, 4'd0, 0, 0, 1, 8'd0, 8'd0, 1'b1};
    b = '{8'h41, 8'h42, 8'd1, 4'd0, 0, 0, 1, 8'd0, 8'd0, 1'b0};
    wait_ready("held");
    sb.push_back('{a.xt, a.xc, a.xok});
    drive_req(a);
    @(posedge clk);
    #1;
    sb.push_back('{b.xt, b.xc, b.xok});
    drive_req(b);
    bad = 0;
    ok  = 1'b0;
    for (int i = 0; i < IDLE_TO + 40; i++) begin
      tick();
      if (bus.rsp_valid) begin
        ok = 1'b1;
        break;
      end
      if (bus.req_ready || (bus.src != a.src)) bad++;
    end
    chk("held_a_rsp", 32'(ok), 32'd1);
    chk("held_not_early", 32'(bad), 32'd0);
    tick();
    chk("held_idle_ready", 32'(bus.req_ready), 32'd1);
    tick();
    chk("held_b_src",   32'(bus.src),       32'(b.src));
    chk("held_b_count", 32'(bus.count),     32'(b.count));
    chk("held_b_busy",  32'(bus.req_ready), 32'd0);
    bus.req_valid = 1'b0;
    wait_rsp("held_b", t_rsp);

    repeat (4) tick();
    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
    $finish;
  end

endmodule
